// File: rtl/gpr_file.sv
// Two-read / one-write register file with a per-register pending-write scoreboard.
// Define GPR_WRITE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module gpr_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic [ADDR_WIDTH-1:0] rs1_addr_in,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_in,
  output logic [DATA_WIDTH-1:0] rs1_data_out,
  output logic [DATA_WIDTH-1:0] rs2_data_out,
  output logic                  rs1_busy_out,
  output logic                  rs2_busy_out,
  input  logic                  rd_wr_en_in,
  input  logic [ADDR_WIDTH-1:0] rd_addr_in,
  input  logic [DATA_WIDTH-1:0] rd_data_in,
  input  logic                  issue_en_in,
  input  logic [ADDR_WIDTH-1:0] issue_addr_in,
  output logic [ADDR_WIDTH:0]   busy_count_out
);
  localparam int NREGS = 2**ADDR_WIDTH;

  logic [NREGS-1:0][DATA_WIDTH-1:0] regs;
  logic [NREGS-1:0]                 busy, busy_nxt;
  logic [ADDR_WIDTH:0]              busy_count, cnt_nxt;

  // Clear on write-back first, then set on issue: a same-cycle issue wins.
  always_comb begin
    busy_nxt = busy;
    if (rd_wr_en_in)  busy_nxt[rd_addr_in]    = 1'b0;
    if (issue_en_in)  busy_nxt[issue_addr_in] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++)
      cnt_nxt = cnt_nxt + {{ADDR_WIDTH{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      regs       <= '0;
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (rd_wr_en_in && rd_addr_in != '0)
        regs[rd_addr_in] <= rd_data_in;
      busy       <= busy_nxt;
      busy_count <= cnt_nxt;
    end
  end

  assign busy_count_out = busy_count;

  logic [1:0][ADDR_WIDTH-1:0] rs_addr;
  logic [1:0][DATA_WIDTH-1:0] rs_data;
  logic [1:0]                 rs_busy;

  assign rs_addr = {rs2_addr_in, rs1_addr_in};

  // regs[0] and busy[0] are held at zero, so index 0 needs no special case.
  for (genvar p = 0; p < 2; p++) begin : g_rd
`ifdef GPR_WRITE_BYPASS_EN
    logic hit;
    assign hit        = rd_wr_en_in && (rd_addr_in != '0) && (rd_addr_in == rs_addr[p]);
    assign rs_data[p] = hit ? rd_data_in : regs[rs_addr[p]];
    assign rs_busy[p] = hit ? (issue_en_in && issue_addr_in == rs_addr[p]) : busy[rs_addr[p]];
`else
    assign rs_data[p] = regs[rs_addr[p]];
    assign rs_busy[p] = busy[rs_addr[p]];
`endif
  end

  assign rs1_data_out = rs_data[0];
  assign rs2_data_out = rs_data[1];
  assign rs1_busy_out = rs_busy[0];
  assign rs2_busy_out = rs_busy[1];
endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: directed scenarios plus a randomized run
// against an array-based reference model.
module tb_gpr_file;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2**AW;

  logic          clock_in = 1'b0;
  logic          reset_in;
  logic [AW-1:0] rs1_addr_in, rs2_addr_in, rd_addr_in, issue_addr_in;
  logic [DW-1:0] rs1_data_out, rs2_data_out, rd_data_in;
  logic          rs1_busy_out, rs2_busy_out, rd_wr_en_in, issue_en_in;
  logic [AW:0]   busy_count_out;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_mem  [NR];
  bit            m_busy [NR];

  gpr_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock_in(clock_in), .reset_in(reset_in),
    .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in),
    .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
    .rs1_busy_out(rs1_busy_out), .rs2_busy_out(rs2_busy_out),
    .rd_wr_en_in(rd_wr_en_in), .rd_addr_in(rd_addr_in), .rd_data_in(rd_data_in),
    .issue_en_in(issue_en_in), .issue_addr_in(issue_addr_in),
    .busy_count_out(busy_count_out)
  );

  always #5 clock_in = ~clock_in;

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef GPR_WRITE_BYPASS_EN
    if (rd_wr_en_in && rd_addr_in != 0 && rd_addr_in == a) return rd_data_in;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef GPR_WRITE_BYPASS_EN
    if (rd_wr_en_in && rd_addr_in != 0 && rd_addr_in == a)
      return issue_en_in && issue_addr_in == a;
`endif
    return m_busy[a];
  endfunction

  function automatic int exp_count();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // Advance the model with the inputs presented at this edge, then cross the edge.
  task automatic tick();
    if (!reset_in) begin
      for (int i = 0; i < NR; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
    end else begin
      if (rd_wr_en_in && rd_addr_in != 0) m_mem[rd_addr_in] = rd_data_in;
      if (rd_wr_en_in) m_busy[rd_addr_in] = 0;
      if (issue_en_in && issue_addr_in != 0) m_busy[issue_addr_in] = 1;
    end
    @(posedge clock_in);
    #1;
  endtask

  task automatic idle();
    rd_wr_en_in = 0; rd_addr_in = '0; rd_data_in = '0;
    issue_en_in = 0; issue_addr_in = '0;
  endtask

  task automatic test_reset();
    reset_in = 0; idle(); rs1_addr_in = '0; rs2_addr_in = '0;
    tick(); tick();
    reset_in = 1;
    for (int i = 0; i < NR; i++) begin
      rs1_addr_in = AW'(i); rs2_addr_in = AW'(NR-1-i); #1;
      checks++;
      if (rs1_data_out !== '0 || rs2_data_out !== '0 || rs1_busy_out !== 1'b0 ||
          rs2_busy_out !== 1'b0 || busy_count_out !== '0) begin
        errors++;
        $display("FAIL reset_read idx=%0d got d1=%h d2=%h b1=%b b2=%b cnt=%0d want all 0",
                 i, rs1_data_out, rs2_data_out, rs1_busy_out, rs2_busy_out, busy_count_out);
      end
    end
  endtask

  task automatic test_write_read();
    idle(); rd_wr_en_in = 1; rd_addr_in = 5; rd_data_in = 32'hDEADBEEF;
    tick(); idle();
    rs1_addr_in = 5; rs2_addr_in = 0; #1;
    checks++;
    if (rs1_data_out !== 32'hDEADBEEF || rs2_data_out !== '0) begin
      errors++;
      $display("FAIL write_read got rs1=%h rs2=%h want deadbeef/0", rs1_data_out, rs2_data_out);
    end
  endtask

  task automatic test_x0();
    idle(); rd_wr_en_in = 1; rd_addr_in = 0; rd_data_in = 32'h12345678;
    tick(); idle();
    rs1_addr_in = 0; rs2_addr_in = 0; #1;
    checks++;
    if (rs1_data_out !== '0 || rs2_data_out !== '0) begin
      errors++;
      $display("FAIL x0_write got rs1=%h rs2=%h want 0", rs1_data_out, rs2_data_out);
    end
    issue_en_in = 1; issue_addr_in = 0;
    tick(); idle(); #1;
    checks++;
    if (busy_count_out !== '0 || rs1_busy_out !== 1'b0) begin
      errors++;
      $display("FAIL x0_issue got cnt=%0d busy=%b want 0/0", busy_count_out, rs1_busy_out);
    end
  endtask

  task automatic test_scoreboard();
    idle(); issue_en_in = 1; issue_addr_in = 7; tick();
    issue_addr_in = 9; tick(); idle();
    rs1_addr_in = 7; rs2_addr_in = 9; #1;
    checks++;
    if (busy_count_out !== 6'd2 || rs1_busy_out !== 1'b1 || rs2_busy_out !== 1'b1) begin
      errors++;
      $display("FAIL issue_two got cnt=%0d b7=%b b9=%b want 2/1/1",
               busy_count_out, rs1_busy_out, rs2_busy_out);
    end
    rd_wr_en_in = 1; rd_addr_in = 7; rd_data_in = 32'h0000_0777;
    tick(); idle(); #1;
    checks++;
    if (busy_count_out !== 6'd1 || rs1_busy_out !== 1'b0 || rs2_busy_out !== 1'b1 ||
        rs1_data_out !== 32'h0000_0777) begin
      errors++;
      $display("FAIL writeback_clear got cnt=%0d b7=%b b9=%b d7=%h want 1/0/1/777",
               busy_count_out, rs1_busy_out, rs2_busy_out, rs1_data_out);
    end
  endtask

  task automatic test_same_cycle();
    idle(); issue_en_in = 1; issue_addr_in = 3;
    rd_wr_en_in = 1; rd_addr_in = 3; rd_data_in = 32'hA5A5A5A5;
    tick(); idle();
    rs1_addr_in = 3; rs2_addr_in = 3; #1;
    checks++;
    if (rs1_busy_out !== 1'b1 || rs1_data_out !== 32'hA5A5A5A5 ||
        rs2_data_out !== 32'hA5A5A5A5 || busy_count_out !== 6'd2) begin
      errors++;
      $display("FAIL issue_wb_same got b=%b d1=%h d2=%h cnt=%0d want 1/a5a5a5a5/a5a5a5a5/2",
               rs1_busy_out, rs1_data_out, rs2_data_out, busy_count_out);
    end
    // Issue to an already-busy index leaves count unchanged.
    issue_en_in = 1; issue_addr_in = 3; tick(); idle(); #1;
    checks++;
    if (busy_count_out !== 6'd2 || rs1_busy_out !== 1'b1) begin
      errors++;
      $display("FAIL reissue got cnt=%0d b=%b want 2/1", busy_count_out, rs1_busy_out);
    end
  endtask

  task automatic test_bypass();
    idle(); rd_wr_en_in = 1; rd_addr_in = 4; rd_data_in = 32'h11; tick();
    rd_data_in = 32'h55; rs1_addr_in = 4; rs2_addr_in = 4; #1;
    checks++;
`ifdef GPR_WRITE_BYPASS_EN
    if (rs1_data_out !== 32'h55 || rs2_data_out !== 32'h55 || rs1_busy_out !== 1'b0) begin
`else
    if (rs1_data_out !== 32'h11 || rs2_data_out !== 32'h11 || rs1_busy_out !== 1'b0) begin
`endif
      errors++;
      $display("FAIL same_cycle_read got d1=%h d2=%h b=%b", rs1_data_out, rs2_data_out, rs1_busy_out);
    end
    tick(); idle(); #1;
    checks++;
    if (rs1_data_out !== 32'h55) begin
      errors++;
      $display("FAIL next_cycle_read got %h want 55", rs1_data_out);
    end
    reset_in = 0; rd_wr_en_in = 1; rd_addr_in = 4; rd_data_in = 32'h77;
    issue_en_in = 1; issue_addr_in = 6;
    tick(); reset_in = 1; idle(); rs2_addr_in = 6; #1;
    checks++;
    if (rs1_data_out !== '0 || busy_count_out !== '0 || rs2_busy_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_during_write got d4=%h cnt=%0d b6=%b want 0/0/0",
               rs1_data_out, busy_count_out, rs2_busy_out);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset_in      = ($urandom_range(0, 39) != 0);
      rd_wr_en_in   = $urandom_range(0, 1);
      rd_addr_in    = AW'($urandom_range(0, 7));
      rd_data_in    = $urandom;
      issue_en_in   = $urandom_range(0, 1);
      issue_addr_in = AW'($urandom_range(0, 7));
      rs1_addr_in   = ($urandom_range(0, 3) == 0) ? rd_addr_in : AW'($urandom_range(0, 7));
      rs2_addr_in   = AW'($urandom_range(0, NR-1));
      #1;
      checks++;
      if (rs1_data_out !== exp_data(rs1_addr_in) || rs2_data_out !== exp_data(rs2_addr_in) ||
          rs1_busy_out !== exp_busy(rs1_addr_in) || rs2_busy_out !== exp_busy(rs2_addr_in) ||
          busy_count_out !== (AW+1)'(exp_count())) begin
        errors++;
        $display("FAIL random c=%0d a1=%0d a2=%0d got d1=%h d2=%h b1=%b b2=%b cnt=%0d want d1=%h d2=%h b1=%b b2=%b cnt=%0d",
                 c, rs1_addr_in, rs2_addr_in, rs1_data_out, rs2_data_out, rs1_busy_out,
                 rs2_busy_out, busy_count_out, exp_data(rs1_addr_in), exp_data(rs2_addr_in),
                 exp_busy(rs1_addr_in), exp_busy(rs2_addr_in), exp_count());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_scoreboard();
    test_same_cycle();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
